// File: rtl/dither_pkg.sv
// dither_pkg: shared definitions for the multi-channel dither generator.
//   dith_mode_e : output distribution selector (off, RPDF, TPDF, high-pass RPDF)
//   DEF_*       : default LFSR length, feedback mask and seed
//   rotl()      : rotate-left of the low 'len' bits of a ROT_W-bit word
package dither_pkg;

  typedef enum logic [1:0] {
    DITH_OFF  = 2'b00,
    DITH_RPDF = 2'b01,
    DITH_TPDF = 2'b10,
    DITH_HP   = 2'b11
  } dith_mode_e;

  localparam int unsigned DEF_LFSR_LEN = 19;
  // x^19 + x^6 + x^2 + x + 1, maximal length
  localparam logic [18:0] DEF_TAPS     = 19'h00047;
  localparam logic [18:0] DEF_SEED     = 19'h00001;

  // Working width of rotl(); LFSR lengths up to this value are supported.
  localparam int unsigned ROT_W = 64;

  // Rotates bits [len-1:0] of v left by n (n < len). Bits at and above len
  // come back as zero, so callers can simply truncate the result.
  function automatic logic [ROT_W-1:0] rotl(input logic [ROT_W-1:0] v,
                                            input int unsigned    len,
                                            input int unsigned    n);
    logic [ROT_W-1:0] r;
    r = '0;
    for (int i = 0; i < ROT_W; i++) begin
      if (i < int'(len)) r[(i + n) % len] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dither_lfsr.sv
// dither_lfsr: one dither channel.
//   clk, rstn : clock, asynchronous active-low reset
//   en        : sample strobe, advances the LFSR and the previous-sample sign
//   load      : reseed strobe (wins over en)
//   seed      : channel seed used on load (already rotated / zero-protected)
//   mode      : distribution select
//   out       : combinational dither word for the current (pre-step) state;
//               the top registers it on the strobe cycle
module dither_lfsr
  import dither_pkg::*;
#(
  parameter int unsigned         LFSR_LEN = DEF_LFSR_LEN,
  parameter logic [LFSR_LEN-1:0] TAPS     = LFSR_LEN'(DEF_TAPS),
  parameter logic [LFSR_LEN-1:0] RST_SEED = LFSR_LEN'(DEF_SEED),
  parameter int unsigned         DW       = 3,
  parameter int unsigned         TPDF_TAP = 9
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 load,
  input  logic [LFSR_LEN-1:0]  seed,
  input  dith_mode_e           mode,
  output logic signed [DW-1:0] out
);

  logic [LFSR_LEN-1:0] s_q, s_d;
  // Previous RPDF sample kept as its sign only: 1 means -1, 0 means +1.
  logic                p_neg_q, p_neg_d;
  logic                a, b;
  logic signed [2:0]   val;

  assign a = s_q[LFSR_LEN-1];
  assign b = s_q[TPDF_TAP];

  always_comb begin
    s_d     = s_q;
    p_neg_d = p_neg_q;
    if (load) begin
      s_d     = seed;
      p_neg_d = 1'b1;
    end else if (en) begin
      s_d     = {s_q[LFSR_LEN-2:0], 1'b0} ^ (a ? TAPS : '0);
      // r(a) is -1 exactly when a is set
      p_neg_d = a;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_q     <= RST_SEED;
      p_neg_q <= 1'b1;
    end else begin
      s_q     <= s_d;
      p_neg_q <= p_neg_d;
    end
  end

  // All modes fit in a 3-bit signed value (-2..+2) before sign extension.
  always_comb begin
    val = 3'b000;
    unique case (mode)
      DITH_OFF:  val = 3'b000;
      DITH_RPDF: val = a ? 3'b111 : 3'b001;
      DITH_TPDF: begin
        // b - a
        unique case ({b, a})
          2'b10:   val = 3'b001;
          2'b01:   val = 3'b111;
          default: val = 3'b000;
        endcase
      end
      DITH_HP: begin
        // r(a) - p: +2 when r=+1,p=-1; -2 when r=-1,p=+1; else 0
        if (!a && p_neg_q)      val = 3'b010;
        else if (a && !p_neg_q) val = 3'b110;
        else                    val = 3'b000;
      end
      default:   val = 3'b000;
    endcase
  end

  assign out = DW'(val);

endmodule

// File: rtl/dither_gen_mc.sv
// dither_gen_mc: multi-channel dither generator for the DAC digital path.
//   clk, rstn  : clock, asynchronous active-low reset
//   en         : sample strobe, one dither word per channel per high cycle
//   mode       : 00 off, 01 RPDF, 10 TPDF, 11 high-pass RPDF
//   load       : seed load strobe (wins over en; no output update)
//   seed_in    : base seed for load; zero falls back to SEED
//   dither     : channel c at bits [c*DW +: DW], two's complement
//   dither_vld : one-cycle pulse when dither was updated
module dither_gen_mc
  import dither_pkg::*;
#(
  parameter int unsigned         LFSR_LEN = DEF_LFSR_LEN,
  parameter logic [LFSR_LEN-1:0] TAPS     = LFSR_LEN'(DEF_TAPS),
  parameter logic [LFSR_LEN-1:0] SEED     = LFSR_LEN'(DEF_SEED),
  parameter int unsigned         NCH      = 2,
  parameter int unsigned         DW       = 3,
  parameter int unsigned         TPDF_TAP = 9
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                load,
  input  logic [LFSR_LEN-1:0] seed_in,
  output logic [NCH*DW-1:0]   dither,
  output logic                dither_vld
);

  logic [LFSR_LEN-1:0] base;
  logic [NCH*DW-1:0]   ch_out;
  logic [NCH*DW-1:0]   dither_q, dither_d;
  logic                vld_q, vld_d;
  dith_mode_e          mode_e;

  // An all-zero seed would lock the LFSR; fall back to SEED instead.
  assign base   = (seed_in == '0) ? SEED : seed_in;
  assign mode_e = dith_mode_e'(mode);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
      // Rotating a nonzero base keeps it nonzero and decorrelates channels.
      localparam int unsigned ROT = (3 * gi) % LFSR_LEN;

      logic [LFSR_LEN-1:0]  ch_seed;
      logic signed [DW-1:0] ch_word;

      assign ch_seed = LFSR_LEN'(rotl(ROT_W'(base), LFSR_LEN, ROT));

      dither_lfsr #(
        .LFSR_LEN (LFSR_LEN),
        .TAPS     (TAPS),
        .RST_SEED (LFSR_LEN'(rotl(ROT_W'(SEED), LFSR_LEN, ROT))),
        .DW       (DW),
        .TPDF_TAP (TPDF_TAP)
      ) u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .load (load),
        .seed (ch_seed),
        .mode (mode_e),
        .out  (ch_word)
      );

      assign ch_out[gi*DW +: DW] = ch_word;
    end
  endgenerate

  always_comb begin
    dither_d = dither_q;
    vld_d    = 1'b0;
    if (en && !load) begin
      dither_d = ch_out;
      vld_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dither_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      dither_q <= dither_d;
      vld_q    <= vld_d;
    end
  end

  assign dither     = dither_q;
  assign dither_vld = vld_q;

endmodule

// File: tb/tb_dither_gen_mc.sv
// tb_dither_gen_mc: self-checking bench for dither_gen_mc. A default
// 19-bit, 2-channel instance runs directed and random stimulus against an
// integer reference model; an 8-bit instance checks the LFSR period.
module tb_dither_gen_mc;

  localparam int L     = 19;
  localparam int TAPS  = 'h47;
  localparam int SEED  = 1;
  localparam int NCH   = 2;
  localparam int DW    = 3;
  localparam int TT    = 9;

  localparam int L8    = 8;
  localparam int TAPS8 = 'h1D;
  localparam int SEED8 = 1;
  localparam int DW8   = 4;
  localparam int TT8   = 5;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0, load = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [L-1:0]     seed_in = '0;
  logic [NCH*DW-1:0] dither;
  logic             dither_vld;

  logic             en8 = 1'b0, load8 = 1'b0;
  logic [1:0]       mode8 = 2'b00;
  logic [L8-1:0]    seed8 = '0;
  logic [DW8-1:0]   dither8;
  logic             vld8;

  always #5 clk = ~clk;

  dither_gen_mc u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .mode       (mode),
    .load       (load),
    .seed_in    (seed_in),
    .dither     (dither),
    .dither_vld (dither_vld)
  );

  dither_gen_mc #(
    .LFSR_LEN (L8),
    .TAPS     (8'h1D),
    .SEED     (8'h01),
    .NCH      (1),
    .DW       (DW8),
    .TPDF_TAP (TT8)
  ) u_dut8 (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en8),
    .mode       (mode8),
    .load       (load8),
    .seed_in    (seed8),
    .dither     (dither8),
    .dither_vld (vld8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int rotl_m(input int v, input int len, input int n);
    if (n == 0) return v;
    return ((v << n) | (v >> (len - n))) & ((1 << len) - 1);
  endfunction

  function automatic int next_state(input int s, input int len, input int taps);
    int msb;
    msb = (s >> (len - 1)) & 1;
    return ((s << 1) & ((1 << len) - 1)) ^ (msb != 0 ? taps : 0);
  endfunction

  function automatic int dith_word(input int s, input int p, input int md,
                                   input int len, input int tt);
    int a, b, r;
    a = (s >> (len - 1)) & 1;
    b = (s >> tt) & 1;
    r = (a != 0) ? -1 : 1;
    case (md)
      0:       return 0;
      1:       return r;
      2:       return b - a;
      default: return r - p;
    endcase
  endfunction

  int m_s[NCH], m_p[NCH], m_d[NCH];
  int m_vld;
  int m8_s, m8_p, m8_d, m8_vld;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_s[c] = rotl_m(SEED, L, (3 * c) % L);
      m_p[c] = -1;
      m_d[c] = 0;
    end
    m_vld = 0;
    m8_s = SEED8; m8_p = -1; m8_d = 0; m8_vld = 0;
  endtask

  // Applies the rules for one rising edge using the inputs present at it.
  task automatic model_edge();
    int base;
    if (load) begin
      base = (seed_in == '0) ? SEED : int'(seed_in);
      for (int c = 0; c < NCH; c++) begin
        m_s[c] = rotl_m(base, L, (3 * c) % L);
        m_p[c] = -1;
      end
      m_vld = 0;
    end else if (en) begin
      for (int c = 0; c < NCH; c++) begin
        m_d[c] = dith_word(m_s[c], m_p[c], int'(mode), L, TT);
        m_p[c] = (((m_s[c] >> (L - 1)) & 1) != 0) ? -1 : 1;
        m_s[c] = next_state(m_s[c], L, TAPS);
      end
      m_vld = 1;
    end else begin
      m_vld = 0;
    end
    if (load8) begin
      m8_s = (seed8 == '0) ? SEED8 : int'(seed8);
      m8_p = -1;
      m8_vld = 0;
    end else if (en8) begin
      m8_d = dith_word(m8_s, m8_p, int'(mode8), L8, TT8);
      m8_p = (((m8_s >> (L8 - 1)) & 1) != 0) ? -1 : 1;
      m8_s = next_state(m8_s, L8, TAPS8);
      m8_vld = 1;
    end else begin
      m8_vld = 0;
    end
  endtask

  function automatic int ch_obs(input int c);
    logic signed [DW-1:0] w;
    w = dither[c*DW +: DW];
    return int'(w);
  endfunction

  function automatic int ch8_obs();
    logic signed [DW8-1:0] w;
    w = dither8;
    return int'(w);
  endfunction

  // One clock: edge, model update, sample 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    $display("[%0t] %s en=%0d ld=%0d md=%0d ch0=%0d ch1=%0d vld=%0d",
             $time, tag, en, load, mode, ch_obs(0), ch_obs(1), dither_vld);
    for (int c = 0; c < NCH; c++)
      check($sformatf("%s ch%0d", tag, c), ch_obs(c), m_d[c]);
    check({tag, " vld"}, int'(dither_vld), m_vld);
  endtask

  task automatic tick8(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, " ch0"}, ch8_obs(), m8_d);
    check({tag, " vld"}, int'(vld8), m8_vld);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " dither"}, int'(dither), 0);
    check({tag, " vld"}, int'(dither_vld), 0);
    check({tag, " dither8"}, int'(dither8), 0);
    check({tag, " vld8"}, int'(vld8), 0);
  endtask

  // Asserts reset between edges, checks the immediate effect, releases.
  task automatic do_reset(input string tag);
    en = 1'b0; load = 1'b0; en8 = 1'b0; load8 = 1'b0;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    reset_checks(tag);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int vld_cnt;
  int zero_seen;
  int first_ret;
  int st;

  initial begin
    model_reset();
    #3;
    reset_checks("por");
    @(negedge clk);
    rstn = 1'b1;

    // RPDF from reset
    mode = 2'b01; en = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick($sformatf("rpdf s%0d", k));
      if (k == 18) check("rpdf s18 ch0 const", ch_obs(0), 1);
      if (k == 19) check("rpdf s19 ch0 const", ch_obs(0), -1);
      if (k == 16) check("rpdf s16 ch1 const", ch_obs(1), -1);
    end
    en = 1'b0;
    tick("idle");
    check("idle vld const", int'(dither_vld), 0);

    // TPDF from reset
    do_reset("rst_tpdf");
    mode = 2'b10; en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick($sformatf("tpdf s%0d", k));
      if (k == 9)  check("tpdf s9 ch0 const", ch_obs(0), 0);
      if (k == 10) check("tpdf s10 ch0 const", ch_obs(0), 1);
      if (k == 11) check("tpdf s11 ch0 const", ch_obs(0), 0);
    end

    // High-pass RPDF from reset
    do_reset("rst_hp");
    mode = 2'b11; en = 1'b1;
    vld_cnt = 0;
    for (int k = 1; k <= 19; k++) begin
      tick($sformatf("hp s%0d", k));
      if (dither_vld) vld_cnt++;
      if (k == 1)  check("hp s1 ch0 const", ch_obs(0), 2);
      if (k == 2)  check("hp s2 ch0 const", ch_obs(0), 0);
      if (k == 19) check("hp s19 ch0 const", ch_obs(0), -2);
    end
    en = 1'b0;
    tick("hp idle");
    if (dither_vld) vld_cnt++;
    check("hp vld count", vld_cnt, 19);

    // Zero-seed load together with en
    load = 1'b1; seed_in = '0; en = 1'b1;
    tick("load0+en");
    check("load vld const", int'(dither_vld), 0);
    check("load hold ch0 const", ch_obs(0), -2);
    load = 1'b0; mode = 2'b01;
    for (int k = 1; k <= 19; k++) begin
      tick($sformatf("reload s%0d", k));
      if (k == 16) check("reload s16 ch1 const", ch_obs(1), -1);
      if (k == 18) check("reload s18 ch0 const", ch_obs(0), 1);
      if (k == 19) check("reload s19 ch0 const", ch_obs(0), -1);
    end

    // Off for 5 strobes, LFSR keeps running
    do_reset("rst_off");
    mode = 2'b00; en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick($sformatf("off s%0d", k));
      check($sformatf("off s%0d zero", k), int'(dither), 0);
    end
    mode = 2'b01;
    tick("off->rpdf s6");
    check("off->rpdf s6 ch0 const", ch_obs(0), 1);

    // Randomized stimulus
    for (int k = 0; k < 400; k++) begin
      en      = ($urandom_range(9) < 7);
      load    = ($urandom_range(19) == 0);
      mode    = 2'($urandom);
      seed_in = ($urandom_range(3) == 0) ? '0 : L'($urandom);
      tick($sformatf("rnd%0d", k));
      if ($urandom_range(99) == 0) do_reset($sformatf("rnd_rst%0d", k));
    end

    // Mid-run reset while strobing
    do_reset("rst_mid_pre");
    mode = 2'b01; en = 1'b1;
    for (int k = 1; k <= 3; k++) tick($sformatf("mid s%0d", k));
    do_reset("mid_rst");
    mode = 2'b01; en = 1'b1;
    tick("mid after s1");
    check("mid after s1 ch0 const", ch_obs(0), 1);
    en = 1'b0;

    // 8-bit period run
    do_reset("rst_p8");
    mode8 = 2'b01; en8 = 1'b1;
    zero_seen = 0;
    first_ret = -1;
    for (int k = 1; k <= 510; k++) begin
      tick8($sformatf("p8 s%0d", k));
      st = int'(u_dut8.gen_ch[0].u_lfsr.s_q);
      if (st == 0) zero_seen = 1;
      if (st == SEED8 && first_ret < 0) first_ret = k;
    end
    $display("[%0t] p8 run: first return at strobe %0d", $time, first_ret);
    check("p8 period", first_ret, 255);
    check("p8 nonzero", zero_seen, 0);
    check("p8 state at 510", st, SEED8);
    check("p8 last vld const", int'(vld8), 1);
    do_reset("p8_mid_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dither_gen_mc.md
# dither_gen_mc

Parametrised multi-channel dither generator for the DAC digital path. Produces one signed dither word per channel per sample strobe, in one of four modes: off, RPDF ±1, TPDF {-1,0,+1} or high-pass RPDF {-2,0,+2}. Each channel runs its own Galois LFSR of configurable length and polynomial, with runtime seed load and zero-seed lockup protection. It sits ahead of the noise-shaper/modulator adder, one dither word per channel per input sample.

## Interface
- LFSR_LEN, 19, LFSR length in bits (≥ 8)
- TAPS, 19'h00047, Galois feedback mask; x^19+x^6+x^2+x+1, maximal, period 2^19−1
- SEED, 19'h00001, reset/fallback seed, must be nonzero
- NCH, 2, channel count (1..8)
- DW, 3, output width per channel (≥ 3), two's complement
- TPDF_TAP, 9, second state bit used in TPDF mode (0..LFSR_LEN−2)
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- en  in  1  sample strobe; one LFSR step and one output word per high cycle
- mode  in  2  00 off, 01 RPDF, 10 TPDF, 11 HP-RPDF
- load  in  1  seed load strobe
- seed_in  in  LFSR_LEN  seed for load
- dither  out  NCH*DW  channel c at bits [c*DW +: DW]
- dither_vld  out  1  one-cycle pulse, dither updated

## Operation
- Per-channel state s_c. Channel seed = rotl(base, 3*c mod LFSR_LEN), with base = SEED at reset and seed_in on load.
- Load: if seed_in == 0, base = SEED (lockup protection). Rotation preserves nonzero.
- Step on en: a = s_c[LFSR_LEN−1] (pre-step MSB); s_c ← {s_c[LFSR_LEN−2:0],0} ^ (a ? TAPS : 0).
- r(a) = +1 if a==0, −1 if a==1.
- Mode 01: out = r(a).
- Mode 10: b = s_c[TPDF_TAP] pre-step; out = b − a ∈ {−1,0,+1}.
- Mode 11: out = r(a) − p_c ∈ {−2,0,+2}; p_c ← r(a) on every en, in all modes.
- Mode 00: out = 0. LFSR and p_c still advance.
- out is sign-extended to DW bits and registered into dither.
- mode is sampled on the en cycle. A change between strobes takes effect at the next strobe and is glitch-free.
- All channels step together. No per-channel enable.

## Timing
- Reset (async, rstn low):
  - s_c = rotl(SEED, 3c)
  - p_c = −1
  - dither = 0
  - dither_vld = 0
- en high at edge k: dither updated and dither_vld = 1 after edge k, for one cycle. Latency is 1 clock.
- en held high for consecutive cycles: one step and one vld per cycle. Full rate is supported.
- load and en in the same cycle: load wins. State is reseeded, p_c is reset to −1, dither holds, and vld = 0.
- load alone: reseeded after the edge. dither holds and vld = 0.
- rstn asserted mid-stream: all state returns to reset values immediately. The first en after release behaves like the first en after power-up.
- State wrap: the sequence repeats every 2^LFSR_LEN−1 steps. There is no special handling at wrap.

## Structure
- Package dither_pkg:
  - mode enum: DITH_OFF, DITH_RPDF, DITH_TPDF, DITH_HP
  - default TAPS/SEED constants
  - rotl function
- Sub-module dither_lfsr: one channel.
  - Contents: LFSR, p_c register and mode mapping.
  - Ports: clk, rstn, en, load, seed, mode, out.
  - Instantiated NCH times via generate.
- Top level: seed fallback, rotation, output/vld registers.

## Test plan
- Reset release with defaults, mode 01, en every cycle:
  - ch0 outputs +1 for strobes 1–18, then −1 at strobe 19.
  - ch1 (seed 1<<3) outputs −1 at strobe 16.
- Mode 10, defaults, from reset: ch0 outputs 0 for strobes 1–9, +1 at strobe 10, 0 at strobe 11.
- Mode 11, defaults, from reset:
  - ch0 outputs +2 at strobe 1, 0 for strobes 2–18, −2 at strobe 19.
  - dither_vld pulses once per en.
- load with seed_in = 0, together with en:
  - State reloads to SEED rotations; no vld, dither holds.
  - Next 19 strobes reproduce the reset sequence.
- Mode 00 for 5 strobes, then mode 01:
  - dither = 0 during the off strobes.
  - Strobe 6 output equals the reset-sequence strobe 6 value (+1), because the LFSR kept advancing.
- Period check with LFSR_LEN = 8, TAPS = 8'h1D:
  - State returns to seed after exactly 255 strobes and never hits 0.
  - Assert rstn mid-run: dither = 0 and vld = 0 immediately.
